// File: rtl/regfile_scoreboard.sv
// Register file with per-register pending-write counters gating instruction issue.
// Define REGFILE_BYPASS_EN to forward same-cycle writeback data to the read ports.
module regfile_scoreboard #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 6,
    parameter int NUM_RD = 2,
    parameter int PEND_W = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_RD-1:0]          rd_use,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    input  logic                       iss_valid,
    input  logic                       iss_wr,
    input  logic [ADDR_W-1:0]          iss_dst,
    output logic                       iss_ready,
    input  logic                       wb_en,
    input  logic [ADDR_W-1:0]          wb_addr,
    input  logic [DATA_W-1:0]          wb_data,
    output logic [(2**ADDR_W)-1:0]     busy,
    output logic                       wb_err
);

    localparam int DEPTH = 2**ADDR_W;
    localparam logic [PEND_W-1:0] CNT_MAX = '1;
    localparam logic [PEND_W-1:0] CNT_ONE = PEND_W'(1);

    logic [DATA_W-1:0] regs [DEPTH];
    logic [PEND_W-1:0] cnt  [DEPTH];
    logic [ADDR_W-1:0] rdAddrA [NUM_RD];

    logic [NUM_RD-1:0] srcBlocked;
    logic              dstFull;
    logic              doIssue;
    logic [DEPTH-1:0]  incVec;
    logic [DEPTH-1:0]  decVec;

    always_comb begin
        for (int i = 0; i < NUM_RD; i++) begin
            rdAddrA[i] = rd_addr[i*ADDR_W +: ADDR_W];
        end
    end

    always_comb begin
        rd_data    = '0;
        srcBlocked = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            rd_data[i*DATA_W +: DATA_W] = regs[rdAddrA[i]];
            srcBlocked[i] = rd_use[i] && (cnt[rdAddrA[i]] != '0);
`ifdef REGFILE_BYPASS_EN
            // The final outstanding write landing now satisfies the source.
            if (wb_en && (wb_addr == rdAddrA[i])) begin
                rd_data[i*DATA_W +: DATA_W] = wb_data;
                if (cnt[rdAddrA[i]] == CNT_ONE) begin
                    srcBlocked[i] = 1'b0;
                end
            end
`endif
        end
    end

    // A saturated destination may still issue if a writeback frees a slot.
    assign dstFull = iss_wr && (cnt[iss_dst] == CNT_MAX)
                     && !(wb_en && (wb_addr == iss_dst));
    assign iss_ready = !(|srcBlocked) && !dstFull;
    assign doIssue   = iss_valid && iss_ready && iss_wr;

    always_comb begin
        incVec = '0;
        decVec = '0;
        busy   = '0;
        for (int r = 0; r < DEPTH; r++) begin
            incVec[r] = doIssue && (iss_dst == ADDR_W'(r));
            decVec[r] = wb_en && (wb_addr == ADDR_W'(r)) && (cnt[r] != '0);
            busy[r]   = (cnt[r] != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < DEPTH; r++) begin
                regs[r] <= '0;
                cnt[r]  <= '0;
            end
            wb_err <= 1'b0;
        end else begin
            if (wb_en) begin
                regs[wb_addr] <= wb_data;
                if (cnt[wb_addr] == '0) begin
                    wb_err <= 1'b1;
                end
            end
            for (int r = 0; r < DEPTH; r++) begin
                if (incVec[r] && !decVec[r]) begin
                    cnt[r] <= cnt[r] + CNT_ONE;
                end else if (decVec[r] && !incVec[r]) begin
                    cnt[r] <= cnt[r] - CNT_ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed scoreboard bench for regfile_scoreboard (default parameters).
module tb_regfile_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  rdUse;
    logic [11:0] rdAddr;
    logic [63:0] rdData;
    logic        issValid;
    logic        issWr;
    logic [5:0]  issDst;
    logic        issReady;
    logic        wbEn;
    logic [5:0]  wbAddr;
    logic [31:0] wbData;
    logic [63:0] busy;
    logic        wbErr;

    int testCnt = 0;
    int failCnt = 0;

    string       tagQ[$];
    logic [63:0] expQ[$];

    regfile_scoreboard dut (
        .clk       (clk),
        .rst       (rst),
        .rd_use    (rdUse),
        .rd_addr   (rdAddr),
        .rd_data   (rdData),
        .iss_valid (issValid),
        .iss_wr    (issWr),
        .iss_dst   (issDst),
        .iss_ready (issReady),
        .wb_en     (wbEn),
        .wb_addr   (wbAddr),
        .wb_data   (wbData),
        .busy      (busy),
        .wb_err    (wbErr)
    );

    always #5 clk = ~clk;

    task automatic idle();
        rst = 1'b0; rdUse = '0; rdAddr = '0;
        issValid = 1'b0; issWr = 1'b0; issDst = '0;
        wbEn = 1'b0; wbAddr = '0; wbData = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expectVal(input string tag, input logic [63:0] val);
        tagQ.push_back(tag);
        expQ.push_back(val);
    endtask

    task automatic checkNext(input logic [63:0] observed);
        string       tag;
        logic [63:0] expected;
        testCnt++;
        if (expQ.size() == 0) begin
            failCnt++;
            $error("FAIL scoreboard_empty observed=%0h", observed);
        end else begin
            tag = tagQ.pop_front();
            expected = expQ.pop_front();
            assert (observed === expected) else begin
                failCnt++;
                $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
            end
        end
    endtask

    task automatic setRd(input logic [5:0] a0, input logic [5:0] a1);
        rdAddr = {a1, a0};
    endtask

    initial begin
        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        expectVal("reset_busy", 64'd0);    checkNext(busy);
        expectVal("reset_ready", 64'd1);   checkNext({63'd0, issReady});
        expectVal("reset_err", 64'd0);     checkNext({63'd0, wbErr});
        expectVal("reset_rd", 64'd0);      checkNext(rdData);

        // Issue a write to r5
        issValid = 1'b1; issWr = 1'b1; issDst = 6'd5;
        #1;
        expectVal("iss5_ready", 64'd1);    checkNext({63'd0, issReady});
        tick();
        idle();
        issValid = 1'b1; rdUse = 2'b01; setRd(6'd5, 6'd5);
        #1;
        expectVal("busy5", 64'd1);         checkNext({63'd0, busy[5]});
        expectVal("src5_blocked", 64'd0);  checkNext({63'd0, issReady});

        // Writeback to r5 while it is a source
        wbEn = 1'b1; wbAddr = 6'd5; wbData = 32'hDEADBEEF;
        #1;
`ifdef REGFILE_BYPASS_EN
        expectVal("byp_ready", 64'd1);     checkNext({63'd0, issReady});
        expectVal("byp_data", 64'hDEADBEEF); checkNext({32'd0, rdData[31:0]});
`else
        expectVal("wb_ready", 64'd0);      checkNext({63'd0, issReady});
`endif
        tick();
        wbEn = 1'b0; rdUse = 2'b11;
        #1;
        expectVal("after_wb_ready", 64'd1); checkNext({63'd0, issReady});
        expectVal("after_wb_data", {32'hDEADBEEF, 32'hDEADBEEF}); checkNext(rdData);
        expectVal("after_wb_busy5", 64'd0); checkNext({63'd0, busy[5]});
        expectVal("after_wb_err", 64'd0);  checkNext({63'd0, wbErr});

        // Saturate r7
        idle();
        issValid = 1'b1; issWr = 1'b1; issDst = 6'd7;
        for (int k = 0; k < 3; k++) begin
            #1;
            expectVal("iss7_ready", 64'd1); checkNext({63'd0, issReady});
            tick();
        end
        #1;
        expectVal("busy7", 64'd1);         checkNext({63'd0, busy[7]});
        expectVal("full7_ready", 64'd0);   checkNext({63'd0, issReady});
        wbEn = 1'b1; wbAddr = 6'd7; wbData = 32'h0000_0077;
        #1;
        expectVal("full7_wb_ready", 64'd1); checkNext({63'd0, issReady});
        tick();
        wbEn = 1'b0;
        #1;
        expectVal("still_full7", 64'd0);   checkNext({63'd0, issReady});
        issValid = 1'b0; issWr = 1'b0;
        wbEn = 1'b1; wbAddr = 6'd7; wbData = 32'h0000_0700;
        tick();
        tick();
        #1;
        expectVal("drain7_busy", 64'd1);   checkNext({63'd0, busy[7]});
        tick();
        wbEn = 1'b0; setRd(6'd7, 6'd0);
        #1;
        expectVal("drain7_idle", 64'd0);   checkNext({63'd0, busy[7]});
        expectVal("drain7_err", 64'd0);    checkNext({63'd0, wbErr});
        expectVal("drain7_data", 64'h0000_0700); checkNext({32'd0, rdData[31:0]});

        // Spurious writeback to r9
        wbEn = 1'b1; wbAddr = 6'd9; wbData = 32'h1234_5678;
        tick();
        wbEn = 1'b0; setRd(6'd9, 6'd9);
        #1;
        expectVal("err9", 64'd1);          checkNext({63'd0, wbErr});
        expectVal("busy9", 64'd0);         checkNext({63'd0, busy[9]});
        expectVal("data9", {32'h1234_5678, 32'h1234_5678}); checkNext(rdData);

        // Register 0 is an ordinary register
        wbEn = 1'b1; wbAddr = 6'd0; wbData = 32'h0000_00A5;
        tick();
        wbEn = 1'b0; setRd(6'd0, 6'd9);
        tick();
        expectVal("err_sticky", 64'd1);    checkNext({63'd0, wbErr});
        expectVal("data0", 64'h0000_00A5); checkNext({32'd0, rdData[31:0]});

        // Pend r3 and r4, then check port-1 blocking
        issValid = 1'b1; issWr = 1'b1; issDst = 6'd3;
        tick();
        issDst = 6'd4;
        tick();
        issWr = 1'b0; rdUse = 2'b10; setRd(6'd3, 6'd4);
        #1;
        expectVal("busy34", 64'h18);       checkNext(busy);
        expectVal("port1_block", 64'd0);   checkNext({63'd0, issReady});
        rdUse = 2'b00;
        #1;
        expectVal("nouse_ready", 64'd1);   checkNext({63'd0, issReady});

        // Reset mid-operation, with a writeback that must be ignored
        rst = 1'b1; wbEn = 1'b1; wbAddr = 6'd9; wbData = 32'hFFFF_FFFF;
        issWr = 1'b1; issDst = 6'd3;
        tick();
        idle();
        issValid = 1'b1; rdUse = 2'b11; setRd(6'd3, 6'd4);
        #1;
        expectVal("rst2_busy", 64'd0);     checkNext(busy);
        expectVal("rst2_ready", 64'd1);    checkNext({63'd0, issReady});
        expectVal("rst2_err", 64'd0);      checkNext({63'd0, wbErr});
        setRd(6'd0, 6'd9);
        #1;
        expectVal("rst2_rd", 64'd0);       checkNext(rdData);

        if (expQ.size() != 0) begin
            failCnt++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", expQ.size());
        end
        $display("[TB] %0d tests run, %0d failed", testCnt, failCnt);
        $finish;
    end

endmodule
